// File: rtl/fp_add_pkg.sv
// Shared types and constants for the fp32 add-reduction sequencer.
package fp_add_pkg;

  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;

  localparam fp32_t FP32_ZERO = '{sign: 1'b0, exp: '0, mant: '0};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRST = 3'd1,
    FETCH = 3'd2,
    ADD   = 3'd3,
    DONE  = 3'd4
  } red_state_e;

endpackage

// File: rtl/fp_add_reduce_seq.sv
// Sequences an external combinational fp32 adder to reduce a valid/ready
// stream into one running sum, one element every two cycles.
//
// state | meaning
// IDLE  | waiting for _go; no element accepted
// FIRST | accept first element straight into acc_q (bypasses the adder)
// FETCH | accept next element into opb_q
// ADD   | capture add_sum into acc_q; decide end of reduction
// DONE  | result presented; wait for out_ready
module fp_add_reduce_seq
  import fp_add_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             _go,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  red_state_e       state_q;
  fp32_t            acc_q;
  fp32_t            opb_q;
  logic [CNT_W-1:0] count_q;
  logic             last_q;
  logic             trunc_q;

  logic accept;
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= FP32_ZERO;
      opb_q   <= FP32_ZERO;
      count_q <= '0;
      last_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (_go) begin
            count_q <= '0;
            trunc_q <= 1'b0;
            state_q <= FIRST;
          end
        end
        FIRST: begin
          if (accept) begin
            acc_q   <= fp32_t'(in_data);
            count_q <= CNT_ONE;
            if (in_last || (MAX_LEN == 1)) begin
              trunc_q <= ~in_last;
              state_q <= DONE;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (accept) begin
            opb_q   <= fp32_t'(in_data);
            last_q  <= in_last;
            count_q <= count_q + CNT_ONE;
            state_q <= ADD;
          end
        end
        ADD: begin
          acc_q <= fp32_t'(add_sum);
          if (last_q || (count_q == CNT_MAX)) begin
            trunc_q <= ~last_q;
            state_q <= DONE;
          end else begin
            state_q <= FETCH;
          end
        end
        DONE: begin
          // A _go arriving with the handshake is deliberately dropped here.
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == FIRST) || (state_q == FETCH);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign add_a     = acc_q;
  assign add_b     = opb_q;
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign out_trunc = trunc_q;

endmodule
